// File: rtl/sincos_pkg.sv
// rtl/sincos_pkg.sv - shared constants, tag type and cos pre-rotation for sincos_sched
package sincos_pkg;

  localparam int FRAC_BITS = 16;
  localparam int INT_BITS  = 20;
  localparam int ANGLE_W   = INT_BITS + FRAC_BITS;
  localparam int TAG_ID_W  = 8;

  localparam logic signed [ANGLE_W-1:0] PI_Q16      = 36'sd205887;
  localparam logic signed [ANGLE_W-1:0] HALF_PI_Q16 = 36'sd102944;
  localparam logic signed [ANGLE_W-1:0] TWO_PI_Q16  = 36'sd411775;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                cos;
  } sincos_tag_t;

  // cos(a) = sin(a + pi/2), folded back into [-pi, pi]
  function automatic logic signed [ANGLE_W-1:0] cos_shift(input logic signed [ANGLE_W-1:0] a);
    logic signed [ANGLE_W-1:0] b;
    b = a + HALF_PI_Q16;
    if (b > PI_Q16) b = b - TWO_PI_Q16;
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter, search starts at the entry after the last grant
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic          w_hit;
  int            w_idx;

  always_comb begin
    grant  = '0;
    w_hit  = 1'b0;
    w_next = r_ptr;
    w_idx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (en && !w_hit && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_hit        = 1'b1;
        w_next       = (w_idx == N_REQ - 1) ? '0 : PW'(w_idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hit) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/sincos_sched.sv
// rtl/sincos_sched.sv - shares one pipelined sin unit among N_REQ requesters
// Tags travel beside the sin pipeline; the whole unit freezes while a response is refused.
module sincos_sched
  import sincos_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int SIN_LAT = 16,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][ANGLE_W-1:0]   req_angle,
  input  logic [N_REQ-1:0]                req_cos,
  output logic                            sin_en,
  output logic [ANGLE_W-1:0]              sin_angle,
  input  logic [ANGLE_W-1:0]              sin_result,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_cos,
  output logic [ANGLE_W-1:0]              rsp_data,
  output logic                            busy
);

  logic                      w_adv;
  logic                      w_arb_en;
  logic [N_REQ-1:0]          w_grant;
  logic                      w_any;
  logic [ID_W-1:0]           w_gid;
  logic                      w_gcos;
  logic signed [ANGLE_W-1:0] w_gangle;
  logic signed [ANGLE_W-1:0] w_issue_angle;
  logic                      w_busy;

  sincos_tag_t               r_tag [0:SIN_LAT];
  logic [ANGLE_W-1:0]        r_angle;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (w_arb_en),
    .grant (w_grant)
  );

  always_comb begin
    w_gid    = '0;
    w_gcos   = 1'b0;
    w_gangle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_gid    = ID_W'(i);
        w_gcos   = req_cos[i];
        w_gangle = req_angle[i];
      end
    end
  end

  assign w_any         = |w_grant;
  assign w_issue_angle = w_gcos ? cos_shift(w_gangle) : w_gangle;

  // Slot 0 pairs its tag with the angle presented to the sin unit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= SIN_LAT; k++) r_tag[k] <= '0;
      r_angle <= '0;
    end else if (w_adv) begin
      r_tag[0] <= '{valid: w_any, id: TAG_ID_W'(w_gid), cos: w_gcos};
      r_angle  <= w_any ? w_issue_angle : '0;
      for (int k = 1; k <= SIN_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k <= SIN_LAT; k++) w_busy = w_busy | r_tag[k].valid;
  end

  assign rsp_valid = r_tag[SIN_LAT].valid & ~rst;
  assign rsp_id    = rst ? '0 : r_tag[SIN_LAT].id[ID_W-1:0];
  assign rsp_cos   = r_tag[SIN_LAT].cos & ~rst;
  assign rsp_data  = sin_result;
  assign w_adv     = ~(rsp_valid & ~rsp_ready);
  assign w_arb_en  = w_adv & ~rst;
  assign sin_en    = w_adv;
  assign req_ready = w_grant;
  assign sin_angle = r_angle;
  assign busy      = w_busy & ~rst;

endmodule

// File: tb/tb_sincos_sched.sv
// tb/tb_sincos_sched.sv - directed bench for sincos_sched with a behavioural enabled sin pipeline
module tb_sincos_sched;

  localparam int N_REQ   = 4;
  localparam int SIN_LAT = 16;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0][35:0] req_angle;
  logic [N_REQ-1:0]       req_cos;
  logic                   sin_en;
  logic [35:0]            sin_angle;
  logic [35:0]            sin_result;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_cos;
  logic [35:0]            rsp_data;
  logic                   busy;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  int     q_id[$];
  int     q_cos[$];
  longint q_data[$];
  int     q_cyc[$];

  sincos_sched #(.N_REQ(N_REQ), .SIN_LAT(SIN_LAT), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_angle  (req_angle),
    .req_cos    (req_cos),
    .sin_en     (sin_en),
    .sin_angle  (sin_angle),
    .sin_result (sin_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_cos    (rsp_cos),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Sin unit stand-in: SIN_LAT enabled stages, contents not cleared by reset
  logic signed [35:0] m_pipe [1:SIN_LAT];

  function automatic logic signed [35:0] sin_q16(input logic [35:0] a);
    real x;
    real y;
    int  r;
    x = real'(longint'($signed(a))) / 65536.0;
    y = $sin(x) * 65536.0;
    r = $rtoi((y < 0.0) ? (y - 0.5) : (y + 0.5));
    return 36'(r);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sin_en) begin
      m_pipe[1] <= sin_q16(sin_angle);
      for (int k = 2; k <= SIN_LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
  end

  assign sin_result = m_pipe[SIN_LAT];

  always @(negedge clk) begin
    #2;
    if (rsp_valid && rsp_ready) begin
      q_id.push_back(int'(rsp_id));
      q_cos.push_back(int'(rsp_cos));
      q_data.push_back(longint'($signed(rsp_data)));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Collapses a value within +/-100 of the target onto the target so chk reports the raw value otherwise
  function automatic longint near(input longint got, input longint exp);
    return ((got - exp <= 100) && (exp - got <= 100)) ? exp : got;
  endfunction

  function automatic void clear_q();
    q_id.delete();
    q_cos.delete();
    q_data.delete();
    q_cyc.delete();
  endfunction

  task automatic single(input int id, input bit c, input longint ang,
                        input longint exp_sa, input longint exp_d);
    int k;
    @(negedge clk);
    req_valid     = 4'(1 << id);
    req_cos[id]   = c;
    req_angle[id] = 36'(ang);
    #1 chk("single_grant", req_ready, 1 << id);
    @(negedge clk);
    req_valid = '0;
    #1 chk("single_sin_angle", longint'($signed(sin_angle)), exp_sa);
    k = 1;
    while (!rsp_valid && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("single_latency", k, 1 + SIN_LAT);
    chk("single_id", rsp_id, id);
    chk("single_cos", rsp_cos, c);
    chk("single_data", near(longint'($signed(rsp_data)), exp_d), exp_d);
    @(negedge clk);
    #1 chk("single_one_pulse", rsp_valid, 0);
  endtask

  longint exp_d [4] = '{0, 16214, 31420, 65536};

  initial begin
    int issued;
    int seen;
    bit stalled;

    rst       = 1'b1;
    req_valid = 4'b0001;
    req_cos   = '0;
    req_angle = '0;
    rsp_ready = 1'b1;

    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sin_en", sin_en, 1);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_rsp_id", rsp_id, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sin_angle", sin_angle, 0);

    single(2, 1'b0, 102944, 102944, 65536);
    single(0, 1'b1, 0, 102944, 65536);
    single(3, 1'b1, 205887, -102944, -65536);

    // Fairness: all requesters valid, pointer back at 0
    req_angle[0] = 36'd0;
    req_angle[1] = 36'd16384;
    req_angle[2] = 36'd32768;
    req_angle[3] = 36'd0;
    req_cos      = 4'b1000;
    clear_q();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = 4'hf;
      #1 chk("rr_grant", req_ready, 1 << (i % 4));
    end
    @(negedge clk);
    req_valid = '0;
    for (int g = 0; g < 60 && q_id.size() < 12; g++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rr_count", q_id.size(), 12);
    for (int k = 0; k < 12 && k < q_id.size(); k++) begin
      chk("rr_rsp_id", q_id[k], k % 4);
      chk("rr_rsp_cos", q_cos[k], (k % 4 == 3) ? 1 : 0);
      chk("rr_rsp_data", near(q_data[k], exp_d[k % 4]), exp_d[k % 4]);
      if (k > 0) chk("rr_back_to_back", q_cyc[k] - q_cyc[k-1], 1);
    end

    // Backpressure with a full pipeline
    clear_q();
    issued  = 0;
    stalled = 1'b0;
    for (int g = 0; g < 300 && !(issued >= 24 && q_id.size() >= 24); g++) begin
      @(negedge clk);
      req_valid = (issued < 24) ? 4'hf : 4'h0;
      if (!stalled && rsp_valid) begin
        stalled   = 1'b1;
        rsp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          #1;
          chk("stall_sin_en", sin_en, 0);
          chk("stall_req_ready", req_ready, 0);
          chk("stall_valid", rsp_valid, 1);
          chk("stall_id", rsp_id, 0);
          chk("stall_data", near(longint'($signed(rsp_data)), 0), 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
      end
      #1;
      if (|req_ready) issued++;
    end
    repeat (5) @(negedge clk);
    chk("bp_stalled", stalled, 1);
    chk("bp_count", q_id.size(), 24);
    for (int k = 0; k < q_id.size(); k++) begin
      chk("bp_rsp_id", q_id[k], k % 4);
      chk("bp_rsp_data", near(q_data[k], exp_d[k % 4]), exp_d[k % 4]);
    end

    // Reset with 10 requests in flight
    clear_q();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 4'hf;
      #1;
    end
    chk("mid_busy_before", busy, 1);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_sin_en", sin_en, 1);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_post_rsp_valid", rsp_valid, 0);
    chk("mid_post_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < SIN_LAT + 4; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || busy) seen++;
    end
    chk("mid_no_stale", seen, 0);
    chk("mid_no_stale_q", q_id.size(), 0);

    // Pointer restarts at 0 after reset
    @(negedge clk);
    req_valid = 4'b1010;
    #1 chk("mid_ptr_reset_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    for (int g = 0; g < 40 && q_id.size() < 1; g++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("mid_new_count", q_id.size(), 1);
    if (q_id.size() > 0) begin
      chk("mid_new_id", q_id[0], 1);
      chk("mid_new_data", near(q_data[0], 16214), 16214);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sincos_sched.md
# sincos_sched

Round-robin scheduler that shares one pipelined `sin` unit among `N_REQ` requesters in the full-Jacobian T-block. Each request asks for sin or cos of a Q19.16 angle. Cos is computed as sin(θ+π/2), wrapped back into [−π, π]. The block tags every issued angle, advances a tag pipeline in lock-step with the unit's clock enable, and returns each result with its requester id. Backpressure is applied by freezing the whole unit.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `SIN_LAT`, 16, enabled clocks from `sin_angle` sampled to `sin_result` valid; must equal the sin unit's latency
- `ID_W`, $clog2(N_REQ), requester id width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept (one-hot or zero)
- `req_angle`  in  N_REQ×36  Q19.16 angle, range [−π, π]
- `req_cos`  in  N_REQ  1 = cos, 0 = sin
- `sin_en`  out  1  drives sin unit `en`
- `sin_angle`  out  36  drives sin unit `angle`
- `sin_result`  in  36  sin unit `sin` output
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer accept
- `rsp_id`  out  ID_W  originating requester
- `rsp_cos`  out  1  echoes `req_cos`
- `rsp_data`  out  36  Q19.16 result, equal to `sin_result`
- `busy`  out  1  any tag slot valid

## Operation
- **Advance.** `adv = !(rsp_valid && !rsp_ready)`, and `sin_en = adv`. Every register in this block updates only when `adv` is high; `rst` overrides `adv`.
- **Arbitration.**
  - Round-robin pointer `ptr`, reset to 0.
  - When `adv` is high, grant the first requester with `req_valid` high, searching from `ptr` upward with wrap.
  - `req_ready[g] = adv` for the granted `g` only. On grant, `ptr ← g+1` (mod N_REQ).
  - With no valid request, no grant is made and `ptr` holds.
- **Preprocess** (combinational, on the granted angle `a`):
  - sin: `a`.
  - cos: `b = a + HALF_PI`, and if `b > PI` then `b − TWO_PI`.
  - Arithmetic is 36-bit two's complement with no saturation. Out-of-range inputs are the requester's responsibility.
- **Issue register (tag slot 0).** On `adv`, loads {valid, id, cos, angle}. With no grant it loads valid=0 and angle=0. `sin_angle` is the slot-0 angle.
- **Tag pipeline.**
  - Slots 1..SIN_LAT hold {valid, id, cos} and shift on `adv`.
  - Slot SIN_LAT drives `rsp_valid`, `rsp_id` and `rsp_cos`. `rsp_data = sin_result`, combinational.
- **Ordering.** Responses leave in issue order, and there is no reordering.
- **Throughput.** One issue per cycle while `adv` is high.

## Timing
- **Reset.** All tag valids = 0, `ptr` = 0, and the slot-0 angle = 0. During and immediately after `rst`: `rsp_valid`, `rsp_id`, `rsp_cos`, `req_ready` and `busy` are 0; `sin_en` is 1.
- **Latency.** A request accepted in cycle t gives `rsp_valid` in cycle t+1+SIN_LAT, assuming no stalls. Each stalled cycle adds one cycle.
- **Stall.** While `rsp_valid && !rsp_ready`:
  - `sin_en` = 0 and `req_ready` = 0.
  - `rsp_valid`, `rsp_id`, `rsp_cos` and `rsp_data` stay stable.
  - The unit's internal state is frozen.
- **Same-cycle accept.** The consumer accepting and a new request being granted in the same cycle are both legal; full throughput is kept.
- **Requester rules.** A requester must hold `req_valid`, `req_angle` and `req_cos` stable until `req_ready`. Dropping `req_valid` before the grant is allowed.
- **Reset mid-operation.** All in-flight tags are discarded. Garbage left inside the sin unit drains under invalid tags, and no stale response is ever emitted.
- **Busy.** `busy` = OR of the valids in slots 0..SIN_LAT. It is used by the upstream sequencer for drain detection.

## Structure
- **Package `sincos_pkg`:**
  - `PI_Q16` = 36'sd205887
  - `HALF_PI_Q16` = 36'sd102944
  - `TWO_PI_Q16` = 36'sd411775
  - `FRAC_BITS` = 16
  - typedef `sincos_tag_t` {valid, id, cos}
- **Sub-module `rr_arbiter`:** parameterised on N_REQ. Inputs `req` and `en`; outputs one-hot `grant`. It owns `ptr` and has its own `clk`/`rst`.
- **Test build.** Instantiate the existing sin unit with `SIN_LAT` matched to its pipeline depth.

## Test plan
- **Single sin.** Requester 2 sends sin with angle 102944. Expect exactly one `rsp_valid` at t+1+SIN_LAT, with `rsp_id`=2, `rsp_cos`=0, and `rsp_data` = 65536±100.
- **Cos, no wrap.** Requester 0 sends cos with angle 0. The cycle after acceptance, `sin_angle` = 102944. The response has `rsp_cos`=1 and data = 65536±100.
- **Cos with wrap.** Cos of angle 205887 gives `sin_angle` = −102944 and a response of −65536±100.
- **Fairness.** All four requesters hold `req_valid` high continuously. Grants run 0,1,2,3,0,1… one per cycle. Responses are back-to-back in the same id order, and no requester waits more than 4 cycles.
- **Backpressure.** With the pipeline full, drop `rsp_ready` for 5 cycles. Expect `sin_en`=0 and `req_ready`=0, with the response held stable. When `rsp_ready` returns, all responses arrive with none lost or duplicated.
- **Reset mid-stream.** Assert `rst` for 1 cycle with 10 requests in flight. From the next cycle on, `rsp_valid`=0 and `busy`=0, and no response appears for at least SIN_LAT+1 cycles unless new requests are issued.
